// File: rtl/alu_seq_unit.sv
// alu_seq_unit: registered ALU with valid/ready handshake, iterative MUL,
// owned CLFZN flag register and condition evaluation for Scond/Bcond/Jcond.
module alu_seq_unit #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [4:0]       alu_cont,
    input  logic [3:0]       cond,
    input  logic             use_carry,
    input  logic [WIDTH-1:0] dst,
    input  logic [WIDTH-1:0] src,
    input  logic [4:0]       flag_en,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       flags
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_MUL,
        S_DONE
    } state_t;

    localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);
    localparam int             MSB  = WIDTH - 1;

    state_t           state_q, state_d;
    logic [4:0]       op_q;
    logic [3:0]       cond_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q, b_q, acc_q, result_q;
    logic [4:0]       fen_q, flags_q, flags_d;
    logic [SHW-1:0]   cnt_q;

    logic             accept;
    logic             cond_ok;
    logic             cin;
    logic [WIDTH:0]   add_w, sub_w;
    logic [WIDTH-1:0] neg_b, mul_sum;
    logic [SHW:0]     amt_s;
    logic [WIDTH-1:0] shl, lsr_n, asr_n, lsr_s, asr_s;
    logic [WIDTH-1:0] alu_res;
    logic             new_c, new_l, new_f, new_n, fl_wr;
    logic [4:0]       new_flags;

    assign accept    = op_valid & op_ready;
    assign op_ready  = (state_q == S_IDLE);
    assign res_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign flags     = flags_q;

    // Stored carry only feeds addc/subc when requested at accept.
    assign cin   = carry_q & flags_q[4];
    assign add_w = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin};
    assign sub_w = {1'b0, a_q} - {1'b0, b_q} - {{WIDTH{1'b0}}, cin};

    // Shift amounts: negative src means a right shift by its magnitude.
    assign neg_b = -b_q;
    assign amt_s = -b_q[SHW:0];
    assign shl   = a_q << b_q[SHW-1:0];
    assign lsr_n = a_q >> neg_b;
    assign asr_n = $signed(a_q) >>> neg_b;
    assign lsr_s = a_q >> amt_s;
    assign asr_s = $signed(a_q) >>> amt_s;

    // One shift-add step: a_q holds the shifted multiplicand, b_q the multiplier.
    assign mul_sum = acc_q + (b_q[0] ? a_q : '0);

    // Condition check against the flag register as it stands now.
    always_comb begin
        cond_ok = 1'b0;
        unique case (cond_q)
            4'b0000: cond_ok = flags_q[1];
            4'b0001: cond_ok = ~flags_q[1];
            4'b0010: cond_ok = flags_q[4];
            4'b0011: cond_ok = ~flags_q[4];
            4'b0100: cond_ok = ~flags_q[3] & ~flags_q[1];
            4'b0101: cond_ok = flags_q[3] | flags_q[1];
            4'b0110: cond_ok = ~flags_q[0] & ~flags_q[1];
            4'b0111: cond_ok = flags_q[0] | flags_q[1];
            4'b1000: cond_ok = flags_q[2];
            4'b1001: cond_ok = ~flags_q[2];
            4'b1010: cond_ok = flags_q[3];
            4'b1011: cond_ok = ~flags_q[3];
            4'b1100: cond_ok = flags_q[0];
            4'b1101: cond_ok = ~flags_q[0];
            4'b1110: cond_ok = 1'b1;
            4'b1111: cond_ok = 1'b0;
        endcase
    end

    // Result and flag candidates for the latched operation.
    always_comb begin
        alu_res = a_q;
        new_c   = 1'b0;
        new_l   = 1'b0;
        new_f   = 1'b0;
        new_n   = 1'b0;
        fl_wr   = 1'b1;
        case (op_q)
            5'b00000: begin
                alu_res = add_w[WIDTH-1:0];
                new_c   = add_w[WIDTH];
                new_f   = (a_q[MSB] == b_q[MSB]) & (add_w[MSB] != a_q[MSB]);
            end
            5'b00001: begin
                alu_res = sub_w[WIDTH-1:0];
                new_c   = sub_w[WIDTH];
                new_f   = (a_q[MSB] != b_q[MSB]) & (sub_w[MSB] != a_q[MSB]);
                new_l   = a_q < b_q;
                new_n   = $signed(a_q) < $signed(b_q);
            end
            5'b00010: alu_res = mul_sum;
            5'b00011: alu_res = a_q & b_q;
            5'b00100: alu_res = a_q | b_q;
            5'b00101: alu_res = a_q ^ b_q;
            5'b00110: alu_res = a_q & ~b_q;
            5'b00111: alu_res = {{(WIDTH-1){1'b0}}, cond_ok};
            5'b01000: alu_res = b_q;
            5'b01001: alu_res = {a_q[WIDTH-9:0], b_q[7:0]};
            5'b01010: alu_res = ~a_q;
            5'b01011: alu_res = b_q[MSB] ? lsr_n : shl;
            5'b01100: alu_res = shl;
            5'b01101: alu_res = lsr_s;
            5'b01110: alu_res = b_q[MSB] ? asr_n : shl;
            5'b01111: alu_res = asr_s;
            5'b10000: alu_res = cond_ok ? add_w[WIDTH-1:0] - {{(WIDTH-1){1'b0}}, cin} : a_q;
            5'b10001: alu_res = cond_ok ? b_q : a_q;
            default:  fl_wr   = 1'b0;
        endcase
    end

    assign new_flags = {new_c, new_l, new_f, (alu_res == '0), new_n};
    assign flags_d   = fl_wr ? ((fen_q & new_flags) | (~fen_q & flags_q)) : flags_q;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = (alu_cont == 5'b00010) ? S_MUL : S_EXEC;
            S_EXEC: state_d = S_DONE;
            S_MUL:  if (cnt_q == LAST) state_d = S_DONE;
            S_DONE: if (res_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Operand latch, multiply iteration and result/flag commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= '0;
            cond_q   <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            fen_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_q    <= alu_cont;
                        cond_q  <= cond;
                        carry_q <= use_carry;
                        a_q     <= dst;
                        b_q     <= src;
                        fen_q   <= flag_en;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                    end
                end
                S_EXEC: begin
                    result_q <= alu_res;
                    flags_q  <= flags_d;
                end
                S_MUL: begin
                    acc_q <= mul_sum;
                    a_q   <= a_q << 1;
                    b_q   <= b_q >> 1;
                    cnt_q <= cnt_q + SHW'(1);
                    if (cnt_q == LAST) begin
                        result_q <= alu_res;
                        flags_q  <= flags_d;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_unit.sv
// tb_alu_seq_unit: directed plus random stimulus for alu_seq_unit,
// checked against an arithmetic reference model of the operation set.
module tb_alu_seq_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic        op_ready;
    logic [4:0]  alu_cont;
    logic [3:0]  cond;
    logic        use_carry;
    logic [15:0] dst;
    logic [15:0] src;
    logic [4:0]  flag_en;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] result;
    logic [4:0]  flags;

    int          checks = 0;
    int          errors = 0;
    logic [4:0]  mflags;
    logic [15:0] last_res;

    alu_seq_unit #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset),
        .op_valid(op_valid), .op_ready(op_ready),
        .alu_cont(alu_cont), .cond(cond), .use_carry(use_carry),
        .dst(dst), .src(src), .flag_en(flag_en),
        .res_valid(res_valid), .res_ready(res_ready),
        .result(result), .flags(flags)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic cond_true(input logic [3:0] c, input logic [4:0] f);
        logic fc, fl, ff, fz, fn, r;
        fc = f[4]; fl = f[3]; ff = f[2]; fz = f[1]; fn = f[0];
        r = 1'b0;
        case (c)
            4'd0:  r = fz;
            4'd1:  r = !fz;
            4'd2:  r = fc;
            4'd3:  r = !fc;
            4'd4:  r = !fl && !fz;
            4'd5:  r = fl || fz;
            4'd6:  r = !fn && !fz;
            4'd7:  r = fn || fz;
            4'd8:  r = ff;
            4'd9:  r = !ff;
            4'd10: r = fl;
            4'd11: r = !fl;
            4'd12: r = fn;
            4'd13: r = !fn;
            4'd14: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Reference: plain integer arithmetic, updates the model flag register.
    task automatic model(input logic [4:0] op, input logic [3:0] cnd, input logic uc,
                         input logic [15:0] d, input logic [15:0] s,
                         input logic [4:0] fen, output logic [15:0] r);
        longint ud, us, sd, ss, t, ts, amt, cin;
        logic   nc, nl, nf, nn, wr, ok;
        logic [4:0] nfl;
        ud = d; us = s;
        sd = $signed(d); ss = $signed(s);
        cin = (uc && mflags[4]) ? 1 : 0;
        ok = cond_true(cnd, mflags);
        nc = 0; nl = 0; nf = 0; nn = 0; wr = 1; r = d;
        case (op)
            5'd0: begin
                t = ud + us + cin; r = 16'(t); nc = (t > 65535);
                ts = sd + ss + cin; nf = (ts > 32767) || (ts < -32768);
            end
            5'd1: begin
                t = ud - us - cin; r = 16'(t); nc = (t < 0);
                ts = sd - ss - cin; nf = (ts > 32767) || (ts < -32768);
                nl = (ud < us); nn = (sd < ss);
            end
            5'd2:  r = 16'(ud * us);
            5'd3:  r = d & s;
            5'd4:  r = d | s;
            5'd5:  r = d ^ s;
            5'd6:  r = d & ~s;
            5'd7:  r = ok ? 16'd1 : 16'd0;
            5'd8:  r = s;
            5'd9:  r = 16'(((ud % 256) * 256) + (us % 256));
            5'd10: r = ~d;
            5'd11, 5'd14: begin
                if (ss < 0) begin
                    amt = -ss;
                    if (op == 5'd11) r = (amt >= 16) ? 16'd0 : 16'(ud >> amt);
                    else             r = 16'(sd >>> ((amt > 15) ? 15 : amt));
                end else begin
                    r = 16'(ud << (us % 16));
                end
            end
            5'd12: r = 16'(ud << (us % 16));
            5'd13: begin
                amt = (32 - (us % 32)) % 32;
                r = (amt >= 16) ? 16'd0 : 16'(ud >> amt);
            end
            5'd15: begin
                amt = (32 - (us % 32)) % 32;
                r = 16'(sd >>> ((amt > 15) ? 15 : amt));
            end
            5'd16: r = ok ? 16'(ud + us) : d;
            5'd17: r = ok ? s : d;
            default: wr = 0;
        endcase
        if (wr) begin
            nfl = {nc, nl, nf, (r == 16'd0), nn};
            for (int i = 0; i < 5; i++) if (fen[i]) mflags[i] = nfl[i];
        end
    endtask

    task automatic do_op(input logic [4:0] op, input logic [3:0] cnd, input logic uc,
                         input logic [15:0] d, input logic [15:0] s,
                         input logic [4:0] fen, input int hold);
        logic [15:0] er;
        int          lat, waitc;
        logic        bad_ready;
        @(negedge clk);
        waitc = 0;
        while (!op_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        check("ready_before_op", op_ready, 1);
        alu_cont = op; cond = cnd; use_carry = uc;
        dst = d; src = s; flag_en = fen;
        op_valid = 1'b1;
        model(op, cnd, uc, d, s, fen, er);
        @(posedge clk);
        #1 op_valid = 1'b0;
        lat = 0;
        bad_ready = 1'b0;
        while (!res_valid && lat < 100) begin
            if (op_ready) bad_ready = 1'b1;
            @(posedge clk);
            #1 lat++;
        end
        check("latency", lat, (op == 5'd2) ? 16 : 1);
        check("ready_low_busy", bad_ready, 0);
        check("result", result, er);
        check("flags", flags, mflags);
        last_res = result;
        if (hold > 0) begin
            op_valid = 1'b1;
            alu_cont = 5'd8;
            dst = 16'($urandom);
            src = 16'($urandom);
            flag_en = 5'b11111;
            repeat (hold) begin
                @(posedge clk);
                #1;
                check("hold_result", result, er);
                check("hold_flags", flags, mflags);
                check("hold_no_accept", {res_valid, op_ready}, 2'b10);
            end
            op_valid = 1'b0;
        end
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        check("release", {res_valid, op_ready}, 2'b01);
    endtask

    // Directed plan steps, reset-during-MUL, then random operations.
    initial begin
        reset = 1'b1; op_valid = 1'b0; res_ready = 1'b0;
        alu_cont = '0; cond = '0; use_carry = 1'b0;
        dst = '0; src = '0; flag_en = '0;
        mflags = '0; last_res = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {op_ready, res_valid, result, flags}, {1'b1, 1'b0, 16'h0, 5'h0});
        @(negedge clk);
        reset = 1'b0;

        do_op(5'd0, 4'd0, 1'b0, 16'h7FFF, 16'h0001, 5'b11111, 0);
        check("plan_add", last_res, 16'h8000);
        check("plan_add_flags", flags, 5'b00100);
        do_op(5'd1, 4'd0, 1'b0, 16'h0003, 16'h0005, 5'b01011, 0);
        check("plan_sub", last_res, 16'hFFFE);
        check("plan_sub_flags", flags, 5'b01101);
        do_op(5'd7, 4'b1100, 1'b0, 16'h0, 16'h0, 5'b00000, 0);
        check("plan_scond_n", last_res, 16'h0001);
        do_op(5'd7, 4'b0000, 1'b0, 16'h0, 16'h0, 5'b00000, 0);
        check("plan_scond_z", last_res, 16'h0000);
        do_op(5'd2, 4'd0, 1'b0, 16'h0123, 16'h0010, 5'b11111, 0);
        check("plan_mul1", last_res, 16'h1230);
        do_op(5'd2, 4'd0, 1'b0, 16'hFFFF, 16'hFFFF, 5'b11111, 0);
        check("plan_mul2", last_res, 16'h0001);
        do_op(5'd14, 4'd0, 1'b0, 16'h8000, 16'hFFFC, 5'b11111, 0);
        check("plan_ashu", last_res, 16'hF800);
        do_op(5'd11, 4'd0, 1'b0, 16'h8000, 16'hFFFC, 5'b11111, 0);
        check("plan_lsh", last_res, 16'h0800);
        do_op(5'd12, 4'd0, 1'b0, 16'h0081, 16'h0004, 5'b11111, 0);
        check("plan_shl", last_res, 16'h0810);
        do_op(5'd1, 4'd0, 1'b0, 16'h1234, 16'h1234, 5'b11111, 5);
        do_op(5'd0, 4'd0, 1'b1, 16'hFFFF, 16'h0000, 5'b11111, 0);
        do_op(5'd11, 4'd0, 1'b0, 16'hFFFF, 16'h8000, 5'b11111, 0);
        do_op(5'd15, 4'd0, 1'b0, 16'h8001, 16'h0010, 5'b11111, 0);
        do_op(5'd13, 4'd0, 1'b0, 16'h8001, 16'h0010, 5'b11111, 0);
        do_op(5'd20, 4'd0, 1'b0, 16'hBEEF, 16'h0001, 5'b11111, 0);

        @(negedge clk);
        alu_cont = 5'd2; dst = 16'h1111; src = 16'h2222; flag_en = 5'b11111;
        op_valid = 1'b1;
        @(posedge clk);
        #1 op_valid = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("reset_mid_mul", {op_ready, res_valid, result, flags}, {1'b1, 1'b0, 16'h0, 5'h0});
        reset = 1'b0;
        mflags = '0;
        do_op(5'd0, 4'd0, 1'b0, 16'h0001, 16'h0001, 5'b11111, 0);
        check("post_reset_add", last_res, 16'h0002);

        for (int k = 0; k < 200; k++) begin
            do_op(5'($urandom_range(0, 31)), 4'($urandom), 1'($urandom),
                  16'($urandom), 16'($urandom), 5'($urandom), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq_unit.md
# alu_seq_unit

Parametrised, registered successor to the combinational ALU control decode. It accepts a decoded 5-bit ALU operation with operands over a valid/ready handshake, executes single-cycle ops in one cycle and MUL iteratively, and holds the result until it is consumed. It owns the CLFZN flag register, with per-flag write enables, and evaluates conditions for Scond, Bcond and Jcond against it. It sits between the decode/register-read stage and writeback.

## Interface
- WIDTH, 16, datapath width in bits (≥8, power of 2)
- SHW, $clog2(WIDTH), shift-amount width
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- op_valid  in  1  operation offered
- op_ready  out  1  unit can accept (high only in IDLE)
- alu_cont  in  5  operation code (see Operation)
- cond  in  4  condition code for 00111/10000/10001
- use_carry  in  1  add/sub includes stored C (addc/subc)
- dst  in  WIDTH  destination operand
- src  in  WIDTH  source operand
- flag_en  in  5  write enables {C,L,F,Z,N}
- res_valid  out  1  result available
- res_ready  in  1  consumer takes result
- result  out  WIDTH  result
- flags  out  5  registered {C,L,F,Z,N}

## Operation
- States: IDLE, EXEC, MUL, DONE. Accept = op_valid & op_ready; all inputs latched at accept.
- IDLE→MUL on accept with alu_cont=00010; IDLE→EXEC on any other accept. EXEC→DONE next edge. MUL→DONE after WIDTH steps. DONE→IDLE on res_ready.
- Ops: 00000 dst+src(+C if use_carry); 00001 dst−src(−C if use_carry); 00010 low WIDTH bits of dst*src, shift-add, one bit per cycle; 00011 AND; 00100 OR; 00101 XOR; 00110 dst & ~src; 00111 cond?1:0; 01000 src; 01001 {dst[WIDTH-9:0], src[7:0]}; 01010 ~dst.
- Shift ops: 01011 LSH, with src signed: negative gives logical right by −src, otherwise left by src[SHW-1:0]. 01100 left by src[SHW-1:0]. 01101 logical right by −src[SHW:0]. 01110 ASHU, same as LSH but right shifts are arithmetic. 01111 arithmetic right by −src[SHW:0].
- Control-flow ops: 10000 cond ? dst+src : dst; 10001 cond ? src : dst.
- Codes 10010–11111 return dst, leave flags unchanged, take the EXEC path.
- Conditions, evaluated against the flags register current at the EXEC/MUL→DONE edge: 0000 Z, 0001 ~Z, 0010 C, 0011 ~C, 0100 ~L&~Z, 0101 L|Z, 0110 ~N&~Z, 0111 N|Z, 1000 F, 1001 ~F, 1010 L, 1011 ~L, 1100 N, 1101 ~N, 1110 1, 1111 0.
- Flags are computed on the final result and written at the edge entering DONE, only where flag_en=1:
  - Add: C = carry out, F = signed overflow, L = N = 0.
  - Sub: C = borrow, F = signed overflow, L = dst<src unsigned, N = dst<src signed.
  - All other ops: C, L, F, N written as 0.
  - Z = (result==0) for all ops.

## Timing
- Reset values: state IDLE, op_ready=1, res_valid=0, result=0, flags=00000, MUL counter 0.
- Single-cycle op accepted at edge N: res_valid=1 and flags updated after edge N+1.
- MUL accepted at edge N: res_valid after edge N+WIDTH.
- result and flags are stable while res_valid=1. op_valid is ignored outside IDLE.
- The handshake completes at the edge where res_valid & res_ready are both high. op_ready returns the following cycle, so there is no same-cycle accept/release; peak throughput is one op per 3 cycles.
- Back-to-back: a cond op accepted after a flag-setting op sees the updated flags.
- Shift amount ≥ WIDTH: left and logical-right give 0; arithmetic-right gives all copies of dst[MSB].
- Add/sub wrap modulo 2^WIDTH.
- Reset in any state, including mid-MUL or while DONE is held, wins: IDLE with reset values on the next edge, and any pending result is dropped.

## Test plan
- WIDTH=16, add 0x7FFF+0x0001, flag_en=11111 -> result 0x8000, C=0 F=1 Z=0 L=0 N=0; res_valid one edge after accept.
- Sub dst=0x0003 src=0x0005, flag_en=01011 -> result 0xFFFE, L=1 N=1 Z=0, C and F unchanged. Then Scond cond=1100 -> 0x0001; cond=0000 -> 0x0000.
- MUL 0x0123*0x0010 -> 0x1230, res_valid exactly 16 edges after accept, op_ready low throughout. MUL 0xFFFF*0xFFFF -> 0x0001.
- dst=0x8000 src=0xFFFC: ASHU -> 0xF800, LSH -> 0x0800. 01100 with src=0x0004 on dst=0x0081 -> 0x0810.
- Hold res_ready low 5 cycles with op_valid high -> result and flags stable, no accept. Raise res_ready -> res_valid low, op_ready high the next cycle.
- Assert reset at cycle 8 of a MUL -> after the edge: op_ready=1, res_valid=0, result=0, flags=00000. A new add 0x0001+0x0001 then returns 0x0002.
